// File: rtl/hms_display_scan.sv
// hms_display_scan: snapshots HH:MM:SS once per frame, converts to BCD by repeated subtraction, and scans a 6-digit 7-segment display.
module hms_display_scan #(
  parameter int P_HOUR_BIT   = 5,
  parameter int P_MIN_BIT    = 6,
  parameter int P_SEC_BIT    = 6,
  parameter int P_SCAN_DIV   = 1000,
  parameter int P_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_HOUR_BIT-1:0] hour,
  input  logic [P_MIN_BIT-1:0]  minute,
  input  logic [P_SEC_BIT-1:0]  second,
  input  logic                  blank,
  output logic [5:0]            o_an,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic                  o_commit
);
  localparam int CW = $clog2(P_SCAN_DIV);
  localparam int HM = P_HOUR_BIT > P_MIN_BIT ? P_HOUR_BIT : P_MIN_BIT;
  localparam int VW = HM > P_SEC_BIT ? HM : P_SEC_BIT;
  localparam logic INV = P_ACTIVE_LOW != 0;
  if (P_SCAN_DIV < 24) begin : g_div_check
    $error("P_SCAN_DIV must be >= 24 so conversion finishes inside slot 5");
  end
  typedef enum logic [2:0] {IDLE, SEC, MIN, HOUR, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx, fb;
  logic [VW-1:0] s_hour, s_min, s_sec, rem;
  logic [3:0] tens;
  logic [3:0] c_d [6];
  logic [3:0] d [6];
  logic h_bad, m_bad, s_bad;
  logic tc, snap, wrap, field, cur_bad, dp_raw;
  logic [6:0] seg_raw;
  logic [5:0] an_raw;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  always_comb begin
    tc = cnt == CW'(P_SCAN_DIV - 1);
    snap = tc && idx == 3'd4;
    wrap = tc && idx == 3'd5;
    field = state == SEC || state == MIN || state == HOUR;
    fb = state == SEC ? 3'd0 : state == MIN ? 3'd2 : 3'd4;
    state_n = state;
    case (state)
      IDLE: if (snap) state_n = SEC;
      SEC: if (rem < VW'(10)) state_n = MIN;
      MIN: if (rem < VW'(10)) state_n = HOUR;
      HOUR: if (rem < VW'(10)) state_n = DONE;
      DONE: if (wrap) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    cur_bad = idx < 3'd2 ? s_bad : idx < 3'd4 ? m_bad : h_bad;
    seg_raw = cur_bad ? 7'h40 : seg7(d[idx]);
    an_raw = 6'd1 << idx;
    dp_raw = (idx == 3'd2 || idx == 3'd4) && !d[0][0] && !s_bad;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      s_hour <= '0;
      s_min <= '0;
      s_sec <= '0;
      rem <= '0;
      tens <= '0;
      c_d <= '{default: '0};
      d <= '{default: '0};
      h_bad <= 1'b0;
      m_bad <= 1'b0;
      s_bad <= 1'b0;
      o_an <= {6{INV}};
      o_seg <= {7{INV}};
      o_dp <= INV;
      o_commit <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
      if (snap && state == IDLE) begin
        s_hour <= VW'(hour);
        s_min <= VW'(minute);
        s_sec <= VW'(second);
        rem <= VW'(second);
        tens <= '0;
      end else if (field) begin
        if (rem >= VW'(10)) begin
          rem <= rem - VW'(10);
          tens <= tens + 4'd1;
        end else begin
          c_d[fb] <= rem[3:0];
          c_d[fb + 3'd1] <= tens;
          rem <= state == SEC ? s_min : s_hour;
          tens <= '0;
        end
      end
      o_commit <= wrap && state == DONE;
      if (wrap && state == DONE) begin
        d <= c_d;
        h_bad <= s_hour > VW'(23);
        m_bad <= s_min > VW'(59);
        s_bad <= s_sec > VW'(59);
      end
      o_an <= {6{INV}} ^ (blank ? 6'd0 : an_raw);
      o_seg <= {7{INV}} ^ (blank ? 7'd0 : seg_raw);
      o_dp <= INV ^ (!blank && dp_raw);
    end
  end
endmodule

// File: tb/tb_hms_display_scan.sv
// tb_hms_display_scan: scoreboard bench; per-slot expected display codes are queued per frame and compared as the scan walks.
module tb_hms_display_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0;
  logic [5:0] second = '0;
  logic blank = 1'b0;
  logic [5:0] o_an;
  logic [6:0] o_seg;
  logic o_dp, o_commit;
  int errors = 0;
  int checks = 0;
  typedef struct packed {logic [5:0] an; logic [6:0] seg; logic dp;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hms_display_scan #(.P_SCAN_DIV(32), .P_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second),
    .blank(blank), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_commit(o_commit)
  );

  function automatic logic [6:0] code(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic exp_t model(input int h, input int m, input int s, input int k);
    exp_t e;
    int dig[6];
    bit bad;
    dig = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    bad = k < 2 ? s > 59 : k < 4 ? m > 59 : h > 23;
    e.an = ~(6'd1 << k);
    e.seg = code(bad ? 10 : dig[k]);
    e.dp = !((k == 2 || k == 4) && s <= 59 && s % 2 == 0);
    return e;
  endfunction

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h);
    minute = 6'(m);
    second = 6'(s);
  endtask

  // Call one cycle before slot 0 appears (the o_commit cycle); returns on the next o_commit cycle.
  task automatic check_frame(input int h, input int m, input int s,
                             input int chg, input int nh, input int nm, input int ns);
    exp_t e;
    int commits = 0;
    for (int k = 0; k < 6; k++) q.push_back(model(h, m, s, k));
    for (int c = 0; c < 192; c++) begin
      @(negedge clk);
      if (c == chg) set_time(nh, nm, ns);
      if (c % 32 == 0) e = q.pop_front();
      if (c % 32 == 0 || c % 32 == 31) begin
        checks++;
        if ({o_an, o_seg, o_dp} !== e) begin
          errors++;
          $display("FAIL scan %0d:%0d:%0d c=%0d: an/seg/dp got %h/%h/%b expected %h/%h/%b",
                   h, m, s, c, o_an, o_seg, o_dp, e.an, e.seg, e.dp);
        end
      end
      if (c < 191 && o_commit) commits++;
    end
    checks++;
    if (commits != 0 || o_commit !== 1'b1) begin
      errors++;
      $display("FAIL commit_period: early commits %0d, commit at c=191 got %b expected 1", commits, o_commit);
    end
  endtask

  task automatic wait_commit();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_commit !== 1'b1 && n < 400);
    checks++;
    if (o_commit !== 1'b1) begin
      errors++;
      $display("FAIL wait_commit: o_commit got %b expected 1 within 400 cycles", o_commit);
    end
  endtask

  task automatic check_dark(input string name);
    checks++;
    if ({o_an, o_seg, o_dp} !== {6'h3F, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL %s: an/seg/dp got %h/%h/%b expected 3f/7f/1", name, o_an, o_seg, o_dp);
    end
  endtask

  task automatic test_reset();
    set_time(12, 34, 56);
    repeat (2) @(negedge clk);
    check_dark("reset_outputs");
    checks++;
    if (o_commit !== 1'b0) begin
      errors++;
      $display("FAIL reset_commit: got %b expected 0", o_commit);
    end
    reset = 1'b0;
    check_frame(0, 0, 0, -1, 0, 0, 0);
    check_frame(12, 34, 56, -1, 0, 0, 0);
  endtask

  task automatic test_snapshot();
    set_time(23, 59, 59);
    check_frame(12, 34, 56, -1, 0, 0, 0);
    check_frame(23, 59, 59, 70, 0, 0, 0);
    check_frame(0, 0, 0, -1, 0, 0, 0);
  endtask

  task automatic test_range();
    set_time(24, 7, 60);
    check_frame(0, 0, 0, -1, 0, 0, 0);
    check_frame(24, 7, 60, -1, 0, 0, 0);
  endtask

  task automatic test_seconds();
    set_time(5, 6, 0);
    check_frame(24, 7, 60, -1, 0, 0, 0);
    check_frame(5, 6, 0, 10, 5, 6, 1);
    check_frame(5, 6, 1, 10, 5, 6, 2);
    check_frame(5, 6, 2, -1, 0, 0, 0);
  endtask

  task automatic test_blank();
    exp_t e;
    int commits = 0;
    repeat (171) @(negedge clk);
    blank = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (o_commit) commits++;
      if (i == 1) check_dark("blank_start");
      if (i == 50) check_dark("blank_end");
    end
    blank = 1'b0;
    @(negedge clk);
    e = model(5, 6, 2, 0);
    checks++;
    if ({o_an, o_seg, o_dp} !== e || commits != 1) begin
      errors++;
      $display("FAIL blank_resume: an/seg/dp %h/%h/%b commits %0d expected %h/%h/%b commits 1",
               o_an, o_seg, o_dp, commits, e.an, e.seg, e.dp);
    end
  endtask

  task automatic test_reset_mid();
    set_time(23, 59, 59);
    wait_commit();
    repeat (162) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_dark("midreset_outputs");
    checks++;
    if (o_commit !== 1'b0) begin
      errors++;
      $display("FAIL midreset_commit: got %b expected 0", o_commit);
    end
    reset = 1'b0;
    check_frame(0, 0, 0, -1, 0, 0, 0);
    check_frame(23, 59, 59, -1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_range();
    test_seconds();
    test_blank();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hms_display_scan.md
Name: hms_display_scan

Overview:
- Reads the hour/minute/second counter outputs and drives a 6-digit multiplexed 7-segment display showing HH:MM:SS.
- Takes a coherent snapshot of the time once per frame and converts it from binary to BCD with a sequential repeated-subtraction FSM.
- Scans one digit per P_SCAN_DIV clocks.
- Sits downstream of the hour/minute/second counters, at the top level beside the tick generator.

Parameters:
- P_HOUR_BIT, 5, hour input width
- P_MIN_BIT, 6, minute input width
- P_SEC_BIT, 6, second input width
- P_SCAN_DIV, 1000, clocks per digit slot; must be >= 24 (elaboration-time check)
- P_ACTIVE_LOW, 1, 1 = segments, dp and anodes active-low; 0 = active-high

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- hour  in  P_HOUR_BIT  binary hour, valid range 0..23
- minute  in  P_MIN_BIT  binary minute, valid range 0..59
- second  in  P_SEC_BIT  binary second, valid range 0..59
- blank  in  1  forces display dark
- o_an  out  6  digit enables; bit0 = sec ones, bit1 = sec tens, bit2 = min ones, bit3 = min tens, bit4 = hour ones, bit5 = hour tens
- o_seg  out  7  segments {g,f,e,d,c,b,a}
- o_dp  out  1  decimal point / colon
- o_commit  out  1  one-cycle pulse when new BCD digits take effect

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: o_an, o_seg and o_dp all inactive; o_commit = 0; prescaler = 0; scan index = 0; committed BCD = 00:00:00; FSM in IDLE.
- Scan prescaler:
  - Counts 0..P_SCAN_DIV-1.
  - On terminal count, the scan index advances 0→1→…→5→0.
  - Output registers reflect the current index one cycle later; the first cycle after reset deasserts shows digit 0 = '0'.
- Snapshot:
  - On the cycle the index changes 4→5, hour/minute/second are latched into snapshot registers and the FSM leaves IDLE.
  - Input changes at any other time do not affect the frame in progress.
- Conversion FSM, states IDLE, SEC, MIN, HOUR, DONE:
  - Each field state starts with tens = 0 and rem = value.
  - While rem >= 10: rem -= 10 and tens++, one subtraction per cycle.
  - When rem < 10, store the digits and move to the next state (one cycle).
  - Worst case is 18 cycles, so DONE is always reached inside slot 5.
- Range check: hour > 23, minute > 59, or second > 59 replaces that field's two digits with a dash code (only segment g lit). The range check is done on the snapshot.
- Commit:
  - On the 5→0 index wrap with the FSM in DONE, the converted digits and range flags load into the display registers.
  - o_commit pulses for 1 cycle and the FSM returns to IDLE.
  - The display registers change only at commit, so there is no tearing within a frame.
- Segment decode, {g..a} active-high: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40.
  - With P_ACTIVE_LOW = 1, o_seg, o_an and o_dp are bitwise-inverted.
  - Active-low values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, dash=3F.
- Decimal point: lit on index 2 and 4 when the committed sec-ones digit is even, giving a colon that blinks at 0.5 Hz. Off on all other indices and whenever the seconds field is a dash.
- blank:
  - When high, the next output cycle has o_an, o_seg and o_dp all inactive.
  - Prescaler, index, snapshot, FSM and commit keep running.
  - Deassert resumes at the current index.
- Reset mid-operation: everything returns to reset values on the next edge; any pending conversion is discarded. The display shows 00:00:00 until the first commit, which occurs on the first 5→0 wrap.

Test Plan:
- P_SCAN_DIV=32, P_ACTIVE_LOW=1, input 12:34:56 held constant → after the first o_commit, o_an walks 3E,3D,3B,37,2F,1F with 32 cycles each, and o_seg follows 02,12,19,30,24,79. o_dp is lit on index 2 and 4 (6 is even).
- Input 23:59:59, then changed to 00:00:00 during slot 2 → the current frame still shows 2,3,5,9,5,9. The next frame, after the snapshot at slot 5 and commit, shows all 40. o_commit pulses exactly once per 192 cycles.
- hour=24, minute=7, second=60 → hour digits and sec digits both show 3F; minute digits show 40 then 78. o_dp is off on all slots (seconds field is a dash).
- blank pulsed high for 50 cycles mid-frame → o_an=3F and o_seg=7F starting the cycle after assertion. After release, the scan index has advanced by the elapsed slots and commits have continued during blank.
- reset asserted for 1 cycle during slot 5 while the FSM is busy → next cycle outputs are inactive with o_commit=0. The display then shows 00:00:00 until the first commit after a full frame, with no stale partial conversion committed.
- Input second counts 0,1,2 across successive frames → o_dp on index 2 and 4 toggles each time seconds changes.
